uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 9 +
 rtl/uart_tx_arbiter_if.sv | 20 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared types and constants for the gesture UART transmit path.
//   arb_state_t : arbiter FSM states
//   ECHO_RESP   : echo response byte
//   GESTURE_HDR : gesture frame header nibble
package gesture_uart_pkg;
   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} arb_state_t;
   localparam logic [7:0] ECHO_RESP   = 8'h55;
   localparam logic [3:0] GESTURE_HDR = 4'hA;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: byte requesters and UART transmitter bundled around the arbiter.
//   req_valid/req_data/req_ready : per-requester byte handshake
//   tx_data/tx_valid/tx_busy     : UART transmitter side
//   grant_id/arb_busy/timeout_err: status
//   master = requesters and UART, slave = arbiter
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 3);
   logic [NUM_REQ-1:0]         req_valid;
   logic [8*NUM_REQ-1:0]       req_data;
   logic [NUM_REQ-1:0]         req_ready;
   logic [7:0]                 tx_data;
   logic                       tx_valid;
   logic                       tx_busy;
   logic [$clog2(NUM_REQ)-1:0] grant_id;
   logic                       arb_busy;
   logic                       timeout_err;
   modport master (output req_valid, req_data, tx_busy,
                   input  req_ready, tx_data, tx_valid, grant_id, arb_busy, timeout_err);
   modport slave  (input  req_valid, req_data, tx_busy,
                   output req_ready, tx_data, tx_valid, grant_id, arb_busy, timeout_err);
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search, first set request at or above ptr_i, wrapping.
//   req_i : request vector
//   ptr_i : search start index
//   gnt_o : one-hot grant (zero when nothing requests)
//   idx_o : index of the granted request
//   any_o : some request is set
module rr_pick #(
   parameter int N = 3
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 any_o
);
   localparam int W = $clog2(N);
   logic [W-1:0] j;
   // Scan from the farthest candidate down so the nearest one to ptr_i wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = W'((int'(ptr_i) + k) % N);
         if (req_i[j]) begin
            gnt_o    = '0;
            gnt_o[j] = 1'b1;
            idx_o    = j;
            any_o    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding bytes from NUM_REQ requesters to one UART transmitter.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : uart_tx_arbiter_if.slave (requester handshake, UART send/busy, status)
module uart_tx_arbiter
   import gesture_uart_pkg::*;
#(
   parameter int NUM_REQ      = 3,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(BUSY_TIMEOUT + 1);
   arb_state_t         state_q, state_d;
   logic [7:0]         tx_data_q, tx_data_d, pick_byte;
   logic               tx_valid_q, tx_valid_d;
   logic [IW-1:0]      grant_q, grant_d, ptr_q, ptr_d, pick_idx;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               timeout_q, timeout_d;
   logic [NUM_REQ-1:0] pick_gnt;
   logic               pick_any, can_accept, hs;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .req_i (bus.req_valid),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // Offers are only made from IDLE with the transmitter free; ready implies valid, so any offer is a handshake.
   assign can_accept = !rst && state_q == IDLE && !bus.tx_busy;
   assign hs         = can_accept && pick_any;

   always_comb begin
      pick_byte = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (pick_gnt[i]) pick_byte = bus.req_data[8*i +: 8];
   end

   always_comb begin
      state_d    = state_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = 1'b0;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      cnt_d      = '0;
      timeout_d  = timeout_q;
      case (state_q)
         IDLE: if (hs) begin
            state_d    = WAIT_BUSY;
            tx_data_d  = pick_byte;
            tx_valid_d = 1'b1;
            grant_d    = pick_idx;
            ptr_d      = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
         end
         WAIT_BUSY: if (bus.tx_busy) state_d = WAIT_DONE;
            else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end
            else cnt_d = cnt_q + 1'b1;
         WAIT_DONE: if (!bus.tx_busy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         grant_q    <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.req_ready   = can_accept ? pick_gnt : '0;
   assign bus.tx_data     = tx_data_q;
   assign bus.tx_valid    = tx_valid_q;
   assign bus.grant_id    = grant_q;
   assign bus.arb_busy    = !rst && state_q != IDLE;
   assign bus.timeout_err = timeout_q;
endmodule
